// File: rtl/ulpi_rx_dma_if.sv
// bmem write handshake between the ULPI receive packer and the AXI bmem bridge.
interface ulpi_rx_dma_if #(
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 32
);
    logic              bmem_wr_en;
    logic [BUS_W-1:0]  bmem_wr_data;
    logic [ADDR_W-1:0] bmem_wr_addr;
    logic              bmem_resp;

    modport master (output bmem_wr_en, bmem_wr_data, bmem_wr_addr, input bmem_resp);
    modport slave  (input bmem_wr_en, bmem_wr_data, bmem_wr_addr, output bmem_resp);
endinterface

// File: rtl/ulpi_rx_dma.sv
// ULPI receive capture: packs PHY bytes little-endian into BUS_W words, buffers
// them in a small FIFO and writes them into a ring buffer over the bmem handshake.
module ulpi_rx_dma #(
    parameter int                BUS_W      = 64,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RING_BYTES = 4096
) (
    input  logic          usb_clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic          dir_i,
    input  logic          nxt_i,
    input  logic [7:0]    data_i,
    ulpi_rx_dma_if.master bmem,
    output logic          pkt_done_o,
    output logic [15:0]   byte_count_o,
    output logic          overflow_o
);
    localparam int LANES = BUS_W / 8;
    localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW    = $clog2(RING_BYTES);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [KW-1:0] LAST_K   = KW'(LANES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]             state;
    logic                   dir_q;
    logic                   en_q;
    logic [KW-1:0]          k;
    logic [LANES-1:0][7:0]  lane_q;
    logic                   full_pend;
    logic [15:0]            byte_cnt;

    logic [LANES-1:0][7:0]  push_word;
    logic                   push;
    logic                   push_ok;
    logic                   pop;

    logic [BUS_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            cnt;
    logic                   empty;
    logic                   full;
    logic [OW-1:0]          off;
    logic [ADDR_W-1:0]      cur_addr;
    logic [BUS_W-1:0]       last_data;
    logic [ADDR_W-1:0]      last_addr;

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            dir_q        <= 1'b0;
            en_q         <= 1'b0;
            k            <= '0;
            lane_q       <= '0;
            full_pend    <= 1'b0;
            byte_cnt     <= '0;
            byte_count_o <= '0;
        end else begin
            dir_q     <= dir_i;
            full_pend <= 1'b0;
            case (state)
                S_IDLE: if (dir_i && !dir_q) state <= S_TURN;
                S_TURN: begin
                    en_q     <= enable_i;
                    k        <= '0;
                    byte_cnt <= '0;
                    state    <= dir_i ? S_RECV : S_IDLE;
                end
                S_RECV: begin
                    if (!dir_i) begin
                        state <= S_FLUSH;
                    end else if (nxt_i && en_q) begin
                        lane_q[k] <= data_i;
                        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                        // a completed word is pushed on the following clock while lane 0 refills
                        if (k == LAST_K) begin
                            k         <= '0;
                            full_pend <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    byte_count_o <= byte_cnt;
                    k            <= '0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // partial words expose only the lanes filled so far; the rest read as zero
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign push_word[i] = (full_pend || (KW'(i) < k)) ? lane_q[i] : 8'h00;
    end

    assign push       = full_pend || (state == S_FLUSH && k != '0);
    assign pkt_done_o = (state == S_FLUSH);

    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign pop      = !empty && bmem.bmem_resp;
    assign push_ok  = push && (!full || pop);
    assign cur_addr = BASE_ADDR + ADDR_W'(off);

    always_ff @(posedge usb_clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            off        <= '0;
            overflow_o <= 1'b0;
            last_data  <= '0;
            last_addr  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (push && !push_ok) overflow_o <= 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr];
                last_addr <= cur_addr;
                off       <= off + OW'(LANES);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // idle bus keeps showing the last accepted write
    assign bmem.bmem_wr_en   = !empty;
    assign bmem.bmem_wr_data = empty ? last_data : mem[rd_ptr];
    assign bmem.bmem_wr_addr = empty ? last_addr : cur_addr;
endmodule

// File: tb/tb_ulpi_rx_dma.sv
// Randomized bench for ulpi_rx_dma: drives ULPI receive packets, answers bmem
// writes with random latency and checks writes against a byte-list packing model.
module tb_ulpi_rx_dma;
    localparam int          BUS_W  = 64;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          RING   = 32;
    localparam int          NB     = BUS_W / 8;
    localparam logic [31:0] BASE   = 32'h0;

    logic        usb_clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_i = 1'b0, dir_i = 1'b0, nxt_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        pkt_done_o;
    logic [15:0] byte_count_o;
    logic        overflow_o;

    ulpi_rx_dma_if #(.BUS_W(BUS_W), .ADDR_W(ADDR_W)) bus ();

    ulpi_rx_dma #(.BUS_W(BUS_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH),
                  .BASE_ADDR(BASE), .RING_BYTES(RING)) dut (
        .usb_clk(usb_clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i),
        .nxt_i(nxt_i), .data_i(data_i), .bmem(bus), .pkt_done_o(pkt_done_o),
        .byte_count_o(byte_count_o), .overflow_o(overflow_o));

    always #5 usb_clk = ~usb_clk;

    int n_cmp = 0, n_bad = 0;
    logic [BUS_W-1:0]  got_d[$], exp_d[$];
    logic [ADDR_W-1:0] got_a[$], exp_a[$];
    int done_cnt = 0;
    int exp_off = 0;
    bit resp_block = 1'b0;
    bit rand_delay = 1'b0;
    int resp_delay = 2;

    // memory side: pulse resp once the request has waited resp_delay cycles
    initial begin
        int wc;
        bus.bmem_resp = 1'b0;
        wc = 0;
        forever begin
            @(posedge usb_clk); #1;
            if (rst || bus.bmem_resp) begin
                bus.bmem_resp = 1'b0;
                wc = 0;
                if (rand_delay) resp_delay = $urandom_range(0, 3);
            end else if (bus.bmem_wr_en && !resp_block) begin
                if (wc >= resp_delay) bus.bmem_resp = 1'b1;
                else wc++;
            end
        end
    end

    always @(negedge usb_clk) begin
        if (!rst) begin
            if (bus.bmem_wr_en && bus.bmem_resp) begin
                got_d.push_back(bus.bmem_wr_data);
                got_a.push_back(bus.bmem_wr_addr);
            end
            if (pkt_done_o) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        got_d.delete(); got_a.delete(); exp_d.delete(); exp_a.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dir_i = 0; nxt_i = 0; data_i = 0; enable_i = 0;
        resp_block = 0; rand_delay = 0; resp_delay = 2;
        repeat (2) @(posedge usb_clk);
        #1 rst = 1'b0;
        exp_off = 0;
        clear_q();
    endtask

    task automatic drive(input logic d, input logic n, input logic [7:0] b);
        @(posedge usb_clk); #1;
        dir_i = d; nxt_i = n; data_i = b;
    endtask

    // dir rise, turnaround, bytes (optional RX CMD before byte cmd_at), end turnaround, FLUSH, idle
    task automatic send_pkt(input logic [7:0] bytes[$], input int cmd_at, input bit en, input bit turn_nxt);
        enable_i = en;
        drive(1, 0, 8'h00);
        drive(1, turn_nxt, 8'hFF);
        foreach (bytes[i]) begin
            if (i == cmd_at) drive(1, 0, 8'h5A);
            drive(1, 1, bytes[i]);
        end
        if (cmd_at == bytes.size()) drive(1, 0, 8'h5A);
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
    endtask

    // expected writes: bytes packed little-endian, trailing partial word zero padded
    task automatic model_pkt(input logic [7:0] bytes[$], input bit en, input int max_words, output int nbytes);
        logic [BUS_W-1:0] w;
        int nw;
        w = '0; nw = 0;
        nbytes = en ? bytes.size() : 0;
        if (en) begin
            for (int i = 0; i < bytes.size(); i++) begin
                w[8*(i%NB) +: 8] = bytes[i];
                if ((i % NB) == NB-1 || i == bytes.size()-1) begin
                    if (nw < max_words) begin
                        exp_d.push_back(w);
                        exp_a.push_back(BASE + ADDR_W'(exp_off));
                        exp_off = (exp_off + NB) % RING;
                    end
                    nw++;
                    w = '0;
                end
            end
        end
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int c = 0; c < budget && got_d.size() < n; c++) @(posedge usb_clk);
        repeat (15) @(posedge usb_clk);
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.bmem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.bmem_wr_en); end
        n_cmp++; if ({bus.bmem_wr_data, bus.bmem_wr_addr} !== '0) begin n_bad++; $display("FAIL reset_data_addr: got %h/%h want 0", bus.bmem_wr_data, bus.bmem_wr_addr); end
        n_cmp++; if ({pkt_done_o, byte_count_o, overflow_o} !== 18'h0) begin n_bad++; $display("FAIL reset_status: got done=%b cnt=%h ovf=%b want 0", pkt_done_o, byte_count_o, overflow_o); end
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        do_reset();
        for (int i = 1; i <= 8; i++) b.push_back(8'(i));
        send_pkt(b, -1, 1, 0);
        n_cmp++; if (byte_count_o !== 16'd8) begin n_bad++; $display("FAIL basic_count: got %0d want 8", byte_count_o); end
        wait_writes(1, 50);
        n_cmp++; if (got_d.size() != 1) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 1", got_d.size()); end
        if (got_d.size() > 0) begin
            n_cmp++; if (got_d[0] !== 64'h0807060504030201 || got_a[0] !== 32'h0) begin n_bad++; $display("FAIL basic_word: got %h@%h want 0807060504030201@0", got_d[0], got_a[0]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_rxcmd();
        logic [7:0] b[$];
        do_reset();
        for (int i = 0; i < 11; i++) b.push_back(8'hA0 + 8'(i));
        send_pkt(b, 4, 1, 0);
        n_cmp++; if (byte_count_o !== 16'd11) begin n_bad++; $display("FAIL rxcmd_count: got %0d want 11", byte_count_o); end
        wait_writes(2, 60);
        n_cmp++; if (got_d.size() != 2) begin n_bad++; $display("FAIL rxcmd_nwrites: got %0d want 2", got_d.size()); end
        if (got_d.size() > 1) begin
            n_cmp++; if (got_d[0] !== 64'hA7A6A5A4A3A2A1A0 || got_a[0] !== 32'h0) begin n_bad++; $display("FAIL rxcmd_w0: got %h@%h want a7a6a5a4a3a2a1a0@0", got_d[0], got_a[0]); end
            n_cmp++; if (got_d[1] !== 64'h0000000000AAA9A8 || got_a[1] !== 32'h8) begin n_bad++; $display("FAIL rxcmd_w1: got %h@%h want aaa9a8@8", got_d[1], got_a[1]); end
        end
    endtask

    task automatic test_turn_nxt();
        logic [7:0] b[$];
        int nb;
        do_reset();
        rand_bytes($urandom_range(9, 16), b);
        model_pkt(b, 1, 99, nb);
        send_pkt(b, -1, 1, 1);
        wait_writes(exp_d.size(), 80);
        n_cmp++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL turn_nwrites: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL turn_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]); end
        end
        if (got_d.size() > 0) begin
            n_cmp++; if (got_d[0][7:0] !== b[0]) begin n_bad++; $display("FAIL turn_first_byte: got %h want %h", got_d[0][7:0], b[0]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        int nb;
        do_reset();
        resp_block = 1;
        rand_bytes(6*NB, b);
        model_pkt(b, 1, DEPTH, nb);
        send_pkt(b, -1, 1, 0);
        n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        resp_block = 0;
        wait_writes(DEPTH, 100);
        n_cmp++; if (got_d.size() != DEPTH) begin n_bad++; $display("FAIL ovf_nwrites: got %0d want %0d", got_d.size(), DEPTH); end
        for (int i = 0; i < got_d.size() && i < DEPTH; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_a[i] !== ADDR_W'(8*i)) begin n_bad++; $display("FAIL ovf_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], 8*i); end
        end
        n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_wrap();
        logic [7:0] b[$];
        int nb;
        do_reset();
        rand_delay = 1;
        rand_bytes(5*NB, b);
        model_pkt(b, 1, 99, nb);
        send_pkt(b, -1, 1, 0);
        wait_writes(5, 100);
        n_cmp++; if (got_d.size() != 5) begin n_bad++; $display("FAIL wrap_nwrites: got %0d want 5", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]); end
        end
        if (got_a.size() == 5) begin
            n_cmp++; if (got_a[4] !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", got_a[4]); end
        end
    endtask

    task automatic test_disabled();
        logic [7:0] b[$], z[$];
        do_reset();
        rand_bytes(3, b);
        send_pkt(b, -1, 1, 0);
        wait_writes(1, 40);
        n_cmp++; if (byte_count_o !== 16'd3) begin n_bad++; $display("FAIL dis_pre_count: got %0d want 3", byte_count_o); end
        got_d.delete(); got_a.delete();
        rand_bytes(5, b);
        send_pkt(b, -1, 0, 0);
        n_cmp++; if (byte_count_o !== 16'd0) begin n_bad++; $display("FAIL dis_count: got %0d want 0", byte_count_o); end
        send_pkt(z, -1, 1, 0);
        n_cmp++; if (done_cnt != 3) begin n_bad++; $display("FAIL dis_done: got %0d pulses want 3", done_cnt); end
        repeat (10) @(posedge usb_clk);
        n_cmp++; if (got_d.size() != 0 || bus.bmem_wr_en !== 1'b0) begin n_bad++; $display("FAIL dis_nowrite: got %0d writes en=%b want 0", got_d.size(), bus.bmem_wr_en); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        int nb;
        do_reset();
        resp_block = 1;
        rand_bytes(2*NB, b);
        b[0] = 8'hC3;
        send_pkt(b, -1, 1, 0);
        n_cmp++; if (bus.bmem_wr_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_pending: got en=%b want 1", bus.bmem_wr_en); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.bmem_wr_en !== 1'b0 || bus.bmem_wr_data !== '0 || bus.bmem_wr_addr !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got en=%b %h@%h want 0", bus.bmem_wr_en, bus.bmem_wr_data, bus.bmem_wr_addr); end
        do_reset();
        rand_bytes(NB, b);
        model_pkt(b, 1, 99, nb);
        send_pkt(b, -1, 1, 0);
        wait_writes(1, 40);
        n_cmp++; if (got_d.size() != 1) begin n_bad++; $display("FAIL rstmid_nwrites: got %0d want 1", got_d.size()); end
        if (got_d.size() > 0) begin
            n_cmp++; if (got_d[0] !== exp_d[0] || got_a[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid_word: got %h@%h want %h@0", got_d[0], got_a[0], exp_d[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        int nb;
        do_reset();
        rand_delay = 1;
        for (int p = 0; p < 12; p++) begin
            rand_bytes($urandom_range(0, 30), b);
            model_pkt(b, ($urandom_range(0, 4) != 0), 99, nb);
            send_pkt(b, int'($urandom_range(0, b.size() + 1)) - 1, nb > 0 || b.size() == 0, $urandom_range(0, 1) == 1);
            n_cmp++; if (byte_count_o !== 16'(nb)) begin n_bad++; $display("FAIL b2b_count%0d: got %0d want %0d", p, byte_count_o, nb); end
        end
        wait_writes(exp_d.size(), 400);
        n_cmp++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL b2b_nwrites: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i]) begin n_bad++; $display("FAIL b2b_word%0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], exp_d[i], exp_a[i]); end
        end
        n_cmp++; if (done_cnt != 12 || overflow_o !== 1'b0) begin n_bad++; $display("FAIL b2b_status: got done=%0d ovf=%b want 12/0", done_cnt, overflow_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rxcmd();
        test_turn_nxt();
        test_overflow();
        test_wrap();
        test_disabled();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
